// File: rtl/adcs_conv_arbiter.sv
// ADC conversion arbiter: round-robin grant of four requesters onto one
// SAR ADC macro, with sample/track, bit-serial successive approximation
// and a one-cycle result strobe back to the granted requester.
module adcs_conv_arbiter #(
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        en,
   input  logic [3:0]  req,
   input  logic [11:0] req_ch,
   input  logic        cmp,
   output logic [3:0]  gnt,
   output logic [3:0]  done,
   output logic [9:0]  data,
   output logic        busy,
   output logic        adc_en,
   output logic        sample_n,
   output logic        dac_rst,
   output logic [2:0]  ch_sel,
   output logic [9:0]  adc_data
);

   localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_CONV   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic [3:0]  bit_r, bit_s;
   logic [1:0]  idx_r, idx_s;
   logic [1:0]  rr_ptr_r, rr_ptr_s;
   logic [1:0]  win_s;
   logic [3:0]  gnt_r, gnt_s;
   logic [3:0]  done_r, done_s;
   logic [9:0]  data_r, data_s;
   logic        busy_r, busy_s;
   logic        adc_en_r;
   logic        sample_n_r, sample_n_s;
   logic        dac_rst_r, dac_rst_s;
   logic [2:0]  ch_sel_r, ch_sel_s;
   logic [9:0]  adc_data_r, adc_data_s;

   // First requester after the pointer, wrapping 3->0; pointer itself last.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] c;
      logic [1:0] w;
      logic       f;
      w = 2'd0;
      f = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         c = p + 2'(k);
         if (!f && r[c]) begin
            w = c;
            f = 1'b1;
         end
      end
      return w;
   endfunction

   // Channel field of requester i from the packed channel bus.
   function automatic logic [2:0] ch_pick(input logic [11:0] r, input logic [1:0] i);
      logic [2:0] c;
      case (i)
         2'd0:    c = r[2:0];
         2'd1:    c = r[5:3];
         2'd2:    c = r[8:6];
         2'd3:    c = r[11:9];
         default: c = 3'd0;
      endcase
      return c;
   endfunction

   // FSM state register.
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; losing the enable anywhere outside IDLE aborts.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en && (req != 4'd0)) state_s = ST_SAMPLE;
            else                     state_s = ST_IDLE;
         end
         ST_SAMPLE: begin
            if (!en)                      state_s = ST_IDLE;
            else if (cnt_r == SAMPLE_LAST) state_s = ST_CONV;
            else                          state_s = ST_SAMPLE;
         end
         ST_CONV: begin
            if (!en)                                           state_s = ST_IDLE;
            else if ((cnt_r == SETTLE_LAST) && (bit_r == 4'd0)) state_s = ST_DONE;
            else                                               state_s = ST_CONV;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Next values of the datapath and of every registered output.
   always_comb begin
      gnt_s      = gnt_r;
      done_s     = 4'd0;
      data_s     = data_r;
      sample_n_s = sample_n_r;
      dac_rst_s  = dac_rst_r;
      ch_sel_s   = ch_sel_r;
      adc_data_s = adc_data_r;
      cnt_s      = cnt_r;
      bit_s      = bit_r;
      idx_s      = idx_r;
      rr_ptr_s   = rr_ptr_r;
      win_s      = rr_pick(req, rr_ptr_r);
      busy_s     = (state_s != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            dac_rst_s = 1'b1;
            if (en && (req != 4'd0)) begin
               idx_s      = win_s;
               gnt_s      = 4'd1 << win_s;
               ch_sel_s   = ch_pick(req_ch, win_s);
               cnt_s      = 8'd0;
               sample_n_s = 1'b0;
            end else begin
               gnt_s      = 4'd0;
               sample_n_s = 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (!en) begin
               gnt_s      = 4'd0;
               sample_n_s = 1'b1;
               dac_rst_s  = 1'b1;
               cnt_s      = 8'd0;
            end else if (cnt_r == SAMPLE_LAST) begin
               sample_n_s = 1'b1;
               dac_rst_s  = 1'b0;
               adc_data_s = 10'h200;
               bit_s      = 4'd9;
               cnt_s      = 8'd0;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         ST_CONV: begin
            if (!en) begin
               gnt_s      = 4'd0;
               sample_n_s = 1'b1;
               dac_rst_s  = 1'b1;
               cnt_s      = 8'd0;
            end else if (cnt_r == SETTLE_LAST) begin
               // Resolve the current trial bit and raise the next one together.
               adc_data_s[bit_r] = cmp;
               if (bit_r != 4'd0) begin
                  adc_data_s[bit_r - 4'd1] = 1'b1;
                  bit_s                    = bit_r - 4'd1;
               end else begin
                  bit_s = bit_r;
               end
               cnt_s = 8'd0;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         ST_DONE: begin
            gnt_s      = 4'd0;
            sample_n_s = 1'b1;
            dac_rst_s  = 1'b1;
            if (en) begin
               data_s        = adc_data_r;
               done_s[idx_r] = 1'b1;
               rr_ptr_s      = idx_r;
            end else begin
               data_s = data_r;
            end
         end
         default: begin
            gnt_s      = 4'd0;
            sample_n_s = 1'b1;
            dac_rst_s  = 1'b1;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         cnt_r      <= 8'd0;
         bit_r      <= 4'd0;
         idx_r      <= 2'd0;
         rr_ptr_r   <= 2'd3;
         gnt_r      <= 4'd0;
         done_r     <= 4'd0;
         data_r     <= 10'd0;
         busy_r     <= 1'b0;
         adc_en_r   <= 1'b0;
         sample_n_r <= 1'b1;
         dac_rst_r  <= 1'b1;
         ch_sel_r   <= 3'd0;
         adc_data_r <= 10'd0;
      end else begin
         cnt_r      <= cnt_s;
         bit_r      <= bit_s;
         idx_r      <= idx_s;
         rr_ptr_r   <= rr_ptr_s;
         gnt_r      <= gnt_s;
         done_r     <= done_s;
         data_r     <= data_s;
         busy_r     <= busy_s;
         adc_en_r   <= en;
         sample_n_r <= sample_n_s;
         dac_rst_r  <= dac_rst_s;
         ch_sel_r   <= ch_sel_s;
         adc_data_r <= adc_data_s;
      end
   end

   assign gnt      = gnt_r;
   assign done     = done_r;
   assign data     = data_r;
   assign busy     = busy_r;
   assign adc_en   = adc_en_r;
   assign sample_n = sample_n_r;
   assign dac_rst  = dac_rst_r;
   assign ch_sel   = ch_sel_r;
   assign adc_data = adc_data_r;

endmodule

// File: tb/tb_adcs_conv_arbiter.sv
// Randomized self-checking bench for adcs_conv_arbiter with an ideal
// comparator model and a round-robin / ideal-SAR reference model.
module tb_adcs_conv_arbiter;

   localparam int SC  = 4;
   localparam int TC  = 2;
   localparam int LAT = SC + 10 * TC + 1;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        en;
   logic [3:0]  req;
   logic [11:0] req_ch;
   logic        cmp;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [9:0]  data;
   logic        busy;
   logic        adc_en;
   logic        sample_n;
   logic        dac_rst;
   logic [2:0]  ch_sel;
   logic [9:0]  adc_data;

   logic [9:0]  vin_code;
   int          errors = 0;
   int          checks = 0;
   int          model_ptr;
   int          ei;
   logic [9:0]  prev_data;
   int          order [5] = '{0, 1, 2, 3, 0};

   always #5 HCLK = ~HCLK;

   // Ideal comparator of the analog macro.
   assign cmp = (vin_code >= adc_data);

   adcs_conv_arbiter #(.SAMPLE_CYCLES(SC), .SETTLE_CYCLES(TC)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .req(req), .req_ch(req_ch),
      .cmp(cmp), .gnt(gnt), .done(done), .data(data), .busy(busy),
      .adc_en(adc_en), .sample_n(sample_n), .dac_rst(dac_rst),
      .ch_sel(ch_sel), .adc_data(adc_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference round robin: first pending index after ptr, wrapping.
   function automatic int model_pick(input logic [3:0] r, input int ptr);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (ptr + k) % 4;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [2:0] model_ch(input logic [11:0] rc, input int i);
      return rc[3*i +: 3];
   endfunction

   task automatic check_reset_values();
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_data", data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_adc_en", adc_en, 0);
      check_eq("rst_sample_n", sample_n, 1);
      check_eq("rst_dac_rst", dac_rst, 1);
      check_eq("rst_ch_sel", ch_sel, 0);
      check_eq("rst_adc_data", adc_data, 0);
   endtask

   // Wait (bounded) for a grant and check the grant-cycle outputs.
   task automatic wait_grant(input int exp_i, input logic [2:0] ech, input int exp_gap);
      int n;
      n = 0;
      while (gnt == 4'd0 && n < 40) begin
         @(negedge HCLK);
         n++;
      end
      check_eq("grant", gnt, 32'd1 << exp_i);
      check_eq("grant_ch_sel", ch_sel, ech);
      check_eq("grant_busy", busy, 1);
      check_eq("grant_sample_n", sample_n, 0);
      check_eq("grant_dac_rst", dac_rst, 1);
      check_eq("done_one_cycle", done, 0);
      if (exp_gap >= 0) check_eq("idle_gap", n, exp_gap);
   endtask

   // Follow a conversion to its done strobe and check result and latency.
   task automatic finish_conv(input int exp_i, input logic [2:0] ech, input logic [9:0] ecode,
                              input bit mid);
      int lat;
      lat = 0;
      while (done == 4'd0 && lat < 60) begin
         @(negedge HCLK);
         lat++;
         if (lat == SC - 1) check_eq("sample_len", sample_n, 0);
         if (lat == SC) begin
            check_eq("hold_sample_n", sample_n, 1);
            check_eq("hold_dac_rst", dac_rst, 0);
            check_eq("first_trial", adc_data, 10'h200);
         end
         if (mid && lat == 8) begin
            req_ch = ~req_ch;
            req    = 4'd0;
         end
      end
      check_eq("latency", lat, LAT);
      check_eq("done", done, 32'd1 << exp_i);
      check_eq("data", data, ecode);
      check_eq("adc_data_hold", adc_data, ecode);
      check_eq("ch_sel_hold", ch_sel, ech);
      check_eq("busy_idle", busy, 0);
      model_ptr = exp_i;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      HRESETn  = 1'b1;
      en       = 1'b0;
      req      = 4'd0;
      req_ch   = 12'd0;
      vin_code = 10'd0;
      repeat (3) @(negedge HCLK);
      check_reset_values();
      HRESETn = 1'b0;
      @(negedge HCLK);
      check_eq("adc_en_off", adc_en, 0);
      en = 1'b1;
      @(negedge HCLK);
      check_eq("adc_en_on", adc_en, 1);
      model_ptr = 3;

      // Single requester 2 on channel 5.
      vin_code = 10'h1A5;
      req_ch   = 12'h140;
      req      = 4'b0100;
      ei = model_pick(req, model_ptr);
      wait_grant(ei, 3'd5, -1);
      finish_conv(ei, 3'd5, 10'h1A5, 1'b0);
      req = 4'd0;

      // Code extremes; requester 0 held high gets re-granted after one idle.
      vin_code = 10'h000;
      req_ch   = 12'h003;
      req      = 4'b0001;
      ei = model_pick(req, model_ptr);
      wait_grant(ei, 3'd3, -1);
      finish_conv(ei, 3'd3, 10'h000, 1'b0);
      vin_code = 10'h3FF;
      ei = model_pick(req, model_ptr);
      wait_grant(ei, 3'd3, 1);
      finish_conv(ei, 3'd3, 10'h3FF, 1'b0);

      // Reset pulsed during SAMPLE.
      req_ch   = 12'($urandom);
      req      = 4'b1111;
      vin_code = 10'($urandom_range(0, 1023));
      ei = model_pick(req, model_ptr);
      wait_grant(ei, model_ch(req_ch, ei), 1);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      #1;
      check_reset_values();
      @(negedge HCLK);
      HRESETn   = 1'b0;
      model_ptr = 3;

      // All four requesting: order 0,1,2,3,0 with one idle cycle between.
      for (int i = 0; i < 5; i++) begin
         vin_code = 10'($urandom_range(0, 1023));
         ei = model_pick(req, model_ptr);
         check_eq("rr_model_order", ei, order[i]);
         wait_grant(order[i], model_ch(req_ch, order[i]), 1);
         finish_conv(order[i], model_ch(req_ch, order[i]), vin_code, 1'b0);
      end

      // Enable dropped on the third CONV cycle, then re-enabled.
      prev_data = data;
      vin_code  = 10'($urandom_range(0, 1023));
      ei = model_pick(req, model_ptr);
      wait_grant(ei, model_ch(req_ch, ei), 1);
      repeat (SC + 2) @(negedge HCLK);
      en = 1'b0;
      @(negedge HCLK);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_gnt", gnt, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_data", data, prev_data);
      check_eq("abort_sample_n", sample_n, 1);
      check_eq("abort_dac_rst", dac_rst, 1);
      check_eq("abort_adc_en", adc_en, 0);
      @(negedge HCLK);
      check_eq("abort_no_done", done, 0);
      en = 1'b1;
      check_eq("abort_same_req", model_pick(req, model_ptr), ei);
      wait_grant(ei, model_ch(req_ch, ei), -1);
      finish_conv(ei, model_ch(req_ch, ei), vin_code, 1'b0);

      // req_ch changed and req dropped mid-CONV.
      req      = 4'b1001;
      req_ch   = 12'($urandom);
      vin_code = 10'($urandom_range(0, 1023));
      ei = model_pick(req, model_ptr);
      wait_grant(ei, model_ch(req_ch, ei), 1);
      finish_conv(ei, model_ch(req_ch, ei), vin_code, 1'b1);

      // Random traffic against the reference model.
      for (int i = 0; i < 10; i++) begin
         req      = 4'($urandom_range(1, 15));
         req_ch   = 12'($urandom);
         vin_code = 10'($urandom_range(0, 1023));
         ei = model_pick(req, model_ptr);
         wait_grant(ei, model_ch(req_ch, ei), 1);
         finish_conv(ei, model_ch(req_ch, ei), vin_code, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adcs_conv_arbiter.md
ADCS_CONV_ARBITER -- requirements
Module: adcs_conv_arbiter

Interface
REQ-001: Parameter SAMPLE_CYCLES, default 4, is the sample/track duration in HCLK cycles (legal range 1..255).
REQ-002: Parameter SETTLE_CYCLES, default 2, is the DAC settle time per SAR bit in HCLK cycles (legal range 1..15).
REQ-003: HCLK  input  1  is the clock; all state SHALL update on the rising edge.
REQ-004: HRESETn  input  1  is the reset: asynchronous, active-high.
REQ-005: en  input  1  is the block enable; it SHALL also drive the macro enable.
REQ-006: req  input  4  is the level conversion request per requester 0..3.
REQ-007: req_ch  input  12  carries the 3-bit channel per requester; requester i uses bits [3i+2:3i].
REQ-008: gnt  output  4  is the one-hot grant, held for the whole conversion.
REQ-009: done  output  4  is a one-hot, one-cycle result strobe to the granted requester.
REQ-010: data  output  10  is the last completed result, held until the next completion.
REQ-011: busy  output  1  SHALL be high in any state other than IDLE.
REQ-012: cmp  input  1  is the macro comparator output; 1 means VIN >= DAC(trial).
REQ-013: adc_en  output  1  drives the macro EN.
REQ-014: sample_n  output  1  drives the macro HOLD; 0 means sampling.
REQ-015: dac_rst  output  1  drives the macro DAC reset.
REQ-016: ch_sel  output  3  drives the macro channel select B.
REQ-017: adc_data  output  10  drives the macro DAC trial code.

Function
REQ-018: FSM states SHALL be IDLE, SAMPLE, CONV and DONE.
REQ-019: IDLE: if en=1 and req!=0, the FSM SHALL grant the first requesting index after rr_ptr (wrapping 3->0), latch its req_ch into ch_sel, set gnt one-hot and enter SAMPLE on the same edge.
REQ-020: SAMPLE: sample_n=0 and dac_rst=1 for exactly SAMPLE_CYCLES cycles, then sample_n=1, dac_rst=0, adc_data=10'h200, bit index=9, enter CONV.
REQ-021: CONV: each bit lasts SETTLE_CYCLES cycles; on the last cycle of the bit, the FSM SHALL clear the trial bit if cmp=0, keep it if cmp=1, and set the next lower bit in the same update.
REQ-022: After bit 0 is resolved, the FSM SHALL enter DONE.
REQ-023: DONE (1 cycle): data<=final adc_data, done[idx]=1, rr_ptr<=idx; next edge gnt<=0, enter IDLE.
REQ-024: Latency from the grant edge to the done-high edge SHALL be SAMPLE_CYCLES+10*SETTLE_CYCLES+1 cycles (25 at defaults).
REQ-025: req_ch SHALL be sampled only at grant; changes mid-conversion SHALL be ignored.
REQ-026: Deassertion of req by the granted requester mid-conversion SHALL NOT abort; done SHALL still pulse.
REQ-027: A requester whose req is still high in IDLE is re-arbitrated; round-robin order SHALL give every other pending requester one turn first.
REQ-028: Between consecutive conversions there SHALL be exactly one IDLE cycle.
REQ-029: adc_en SHALL equal en, registered one cycle.
REQ-030: en=0 in any non-IDLE state SHALL abort: next edge IDLE, gnt=0, no done, data unchanged, sample_n=1, dac_rst=1, rr_ptr unchanged.
REQ-031: In IDLE: sample_n=1, dac_rst=1, adc_data holds the last code, and ch_sel holds its value.

Reset
REQ-032: While HRESETn=1: gnt=0, done=0, data=0, busy=0, adc_en=0, sample_n=1, dac_rst=1, ch_sel=0, adc_data=0, rr_ptr=3 (requester 0 first), FSM=IDLE.
REQ-033: Reset asserted mid-conversion SHALL abort immediately with no done pulse.

Verification
REQ-034: Comparator model cmp=(vin_code>=adc_data), vin_code=0x1A5, req=4'b0100, req_ch[8:6]=5 -> gnt=4'b0100, ch_sel=5, done=4'b0100 exactly 25 cycles after the grant, data=0x1A5.
REQ-035: vin_code=0x000, then 0x3FF -> data=0x000, then 0x3FF; the trial sequence starts 0x200 in both cases.
REQ-036: req=4'b1111 held continuously -> grant order 0,1,2,3,0, one IDLE cycle between consecutive conversions.
REQ-037: en dropped on the 3rd CONV cycle -> IDLE next edge, no done, data unchanged, sample_n=1, dac_rst=1; re-enable -> same requester granted again.
REQ-038: HRESETn pulsed during SAMPLE -> all outputs at the REQ-032 values; the first grant after release goes to requester 0.
REQ-039: req_ch changed and req dropped mid-CONV -> ch_sel unchanged, done still pulses with the correct code.
